// File: rtl/pe_tile_pkg.sv
// Shared types for the parametrised PE tile: opcodes, config module ids, sides, SB select encoding.
// Pure declarations; no timing or flow control of its own.
package pe_tile_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'd0,
    OP_OR  = 2'd1,
    OP_XOR = 2'd2,
    OP_ADD = 2'd3
  } pe_op_e;

  localparam logic [7:0] MOD_CLB    = 8'd4;
  localparam logic [7:0] MOD_CB1    = 8'd5;
  localparam logic [7:0] MOD_CB0    = 8'd6;
  localparam logic [7:0] MOD_SB     = 8'd7;
  localparam logic [7:0] MOD_SB_REG = 8'd8;
  localparam logic [7:0] MOD_CTRL   = 8'd9;

  typedef enum logic [1:0] {
    SIDE_N = 2'd0,
    SIDE_E = 2'd1,
    SIDE_S = 2'd2,
    SIDE_W = 2'd3
  } side_e;

  localparam int NUM_SIDES = 4;

  // Non-zero selects rotate clockwise from the output's own side.
  typedef enum logic [1:0] {
    SB_SEL_PE   = 2'd0,
    SB_SEL_ROT1 = 2'd1,
    SB_SEL_ROT2 = 2'd2,
    SB_SEL_ROT3 = 2'd3
  } sb_sel_e;

  typedef struct packed {
    logic [3:0]  rsvd;
    logic [3:0]  word;
    logic [7:0]  mod_id;
    logic [15:0] tile;
  } cfg_addr_t;

  function automatic int sb_src_side(input int side, input int rot);
    return (side + rot) % NUM_SIDES;
  endfunction

endpackage

// File: rtl/connect_box_param.sv
// Connect box: select register plus 2*TRACKS:1 mux over north inputs then north outputs.
// Mux is combinational (0 cycles); select updates on the write edge; no backpressure.
module connect_box_param #(
  parameter int WIDTH    = 1,
  parameter int TRACKS   = 4,
  parameter int CB_SEL_W = $clog2(2*TRACKS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_we_i,
  input  logic [CB_SEL_W-1:0]      cfg_sel_i,
  input  logic [TRACKS*WIDTH-1:0]  in_trk_i,
  input  logic [TRACKS*WIDTH-1:0]  out_trk_i,
  output logic [CB_SEL_W-1:0]      sel_o,
  output logic [WIDTH-1:0]         dat_o
);

  logic [CB_SEL_W-1:0] sel_q, sel_d;

  assign sel_d = cfg_we_i ? cfg_sel_i : sel_q;
  assign sel_o = sel_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sel_q <= '0;
    else        sel_q <= sel_d;
  end

  // Selects at or beyond 2*TRACKS fall through to zero.
  always_comb begin
    dat_o = '0;
    for (int k = 0; k < TRACKS; k++) begin
      if (int'(sel_q) == k)          dat_o = in_trk_i[k*WIDTH +: WIDTH];
      if (int'(sel_q) == TRACKS + k) dat_o = out_trk_i[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/pe_tile_param.sv
// Fabric tile: 4-op PE fed by two connect boxes, switch box with per-output optional flop, config r/w.
// PE and readback are 1-cycle registered; SB outputs 0 or 1 cycle; no backpressure on any path.
module pe_tile_param
  import pe_tile_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int TRACKS   = 4,
  parameter int CB_SEL_W = $clog2(2*TRACKS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [15:0]                tile_id,
  input  logic [31:0]                config_addr,
  input  logic [31:0]                config_data,
  input  logic                       config_wr,
  input  logic                       config_rd,
  output logic [31:0]                config_rd_data,
  output logic                       config_rd_valid,
  input  logic [4*TRACKS*WIDTH-1:0]  in_wires,
  output logic [4*TRACKS*WIDTH-1:0]  out_wires
);

  localparam int NOUT   = NUM_SIDES * TRACKS;
  localparam int TRK_W  = TRACKS * WIDTH;
  localparam int N_BASE = int'(SIDE_N) * TRK_W;

  cfg_addr_t addr;
  logic      tile_hit, wr_hit, rd_hit, word0;
  logic      unused_addr_bits;

  pe_op_e                     op_q, op_d;
  logic                       pe_en_q, pe_en_d;
  logic [WIDTH-1:0]           pe_q, pe_d, pe_res, op0, op1;
  logic [NOUT-1:0][1:0]       sb_sel_q, sb_sel_d;
  logic [NOUT-1:0]            sb_reg_q, sb_reg_d;
  logic [NOUT-1:0][WIDTH-1:0] sb_mux, sb_flop_q;
  logic [31:0]                rd_word, rd_dat_q;
  logic                       rd_vld_q;
  logic [CB_SEL_W-1:0]        cb0_sel, cb1_sel;
  logic                       cb0_we, cb1_we;

  assign addr             = cfg_addr_t'(config_addr);
  assign unused_addr_bits = ^addr.rsvd;
  assign tile_hit         = (addr.tile == tile_id);
  assign wr_hit           = config_wr && tile_hit;
  assign rd_hit           = config_rd && tile_hit;
  assign word0            = (addr.word == 4'd0);
  assign cb0_we           = wr_hit && word0 && (addr.mod_id == MOD_CB0);
  assign cb1_we           = wr_hit && word0 && (addr.mod_id == MOD_CB1);

  connect_box_param #(.WIDTH(WIDTH), .TRACKS(TRACKS), .CB_SEL_W(CB_SEL_W)) cb0 (
    .clk       (clk),
    .reset     (reset),
    .cfg_we_i  (cb0_we),
    .cfg_sel_i (config_data[CB_SEL_W-1:0]),
    .in_trk_i  (in_wires[N_BASE +: TRK_W]),
    .out_trk_i (out_wires[N_BASE +: TRK_W]),
    .sel_o     (cb0_sel),
    .dat_o     (op0)
  );

  // Feedback from out_wires is safe: every SB source is an input or a flop.
  connect_box_param #(.WIDTH(WIDTH), .TRACKS(TRACKS), .CB_SEL_W(CB_SEL_W)) cb1 (
    .clk       (clk),
    .reset     (reset),
    .cfg_we_i  (cb1_we),
    .cfg_sel_i (config_data[CB_SEL_W-1:0]),
    .in_trk_i  (in_wires[N_BASE +: TRK_W]),
    .out_trk_i (out_wires[N_BASE +: TRK_W]),
    .sel_o     (cb1_sel),
    .dat_o     (op1)
  );

  always_comb begin
    op_d     = op_q;
    pe_en_d  = pe_en_q;
    sb_sel_d = sb_sel_q;
    sb_reg_d = sb_reg_q;
    if (wr_hit) begin
      case (addr.mod_id)
        MOD_CLB:  if (word0) op_d = pe_op_e'(config_data[1:0]);
        MOD_CTRL: if (word0) pe_en_d = config_data[0];
        MOD_SB: begin
          for (int o = 0; o < NOUT; o++)
            if (addr.word == 4'(o / 16)) sb_sel_d[o] = config_data[2*(o%16) +: 2];
        end
        MOD_SB_REG: begin
          for (int o = 0; o < NOUT; o++)
            if (addr.word == 4'(o / 32)) sb_reg_d[o] = config_data[o%32];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pe_res = '0;
    case (op_q)
      OP_AND:  pe_res = op0 & op1;
      OP_OR:   pe_res = op0 | op1;
      OP_XOR:  pe_res = op0 ^ op1;
      OP_ADD:  pe_res = op0 + op1;
      default: pe_res = '0;
    endcase
  end

  assign pe_d = pe_en_q ? pe_res : pe_q;

  always_comb begin
    sb_mux = '0;
    for (int s = 0; s < NUM_SIDES; s++) begin
      for (int t = 0; t < TRACKS; t++) begin
        if (sb_sel_q[s*TRACKS+t] == SB_SEL_PE)
          sb_mux[s*TRACKS+t] = pe_q;
        else
          sb_mux[s*TRACKS+t] =
            in_wires[(sb_src_side(s, int'(sb_sel_q[s*TRACKS+t]))*TRACKS + t)*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    out_wires = '0;
    for (int o = 0; o < NOUT; o++)
      out_wires[o*WIDTH +: WIDTH] = sb_reg_q[o] ? sb_flop_q[o] : sb_mux[o];
  end

  // Reads see pre-write state, so a same-cycle read/write returns the old word.
  always_comb begin
    rd_word = '0;
    case (addr.mod_id)
      MOD_CLB:  if (word0) rd_word[1:0] = op_q;
      MOD_CB1:  if (word0) rd_word[CB_SEL_W-1:0] = cb1_sel;
      MOD_CB0:  if (word0) rd_word[CB_SEL_W-1:0] = cb0_sel;
      MOD_CTRL: if (word0) rd_word[0] = pe_en_q;
      MOD_SB: begin
        for (int o = 0; o < NOUT; o++)
          if (addr.word == 4'(o / 16)) rd_word[2*(o%16) +: 2] = sb_sel_q[o];
      end
      MOD_SB_REG: begin
        for (int o = 0; o < NOUT; o++)
          if (addr.word == 4'(o / 32)) rd_word[o%32] = sb_reg_q[o];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q      <= OP_AND;
      pe_en_q   <= 1'b1;
      pe_q      <= '0;
      sb_sel_q  <= '0;
      sb_reg_q  <= '0;
      sb_flop_q <= '0;
      rd_dat_q  <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      op_q      <= op_d;
      pe_en_q   <= pe_en_d;
      pe_q      <= pe_d;
      sb_sel_q  <= sb_sel_d;
      sb_reg_q  <= sb_reg_d;
      sb_flop_q <= sb_mux;
      rd_vld_q  <= rd_hit;
      if (rd_hit) rd_dat_q <= rd_word;
    end
  end

  assign config_rd_data  = rd_dat_q;
  assign config_rd_valid = rd_vld_q;

endmodule

// File: tb/tb_pe_tile_param.sv
// Bench for pe_tile_param (WIDTH=4, TRACKS=4): vector tables, directed corner sequences,
// then randomized traffic against a behavioural tile model.
module tb_pe_tile_param;

  localparam int W  = 4;
  localparam int T  = 4;
  localparam int NO = 4*T;

  logic           clk = 1'b0;
  logic           reset;
  logic [15:0]    tile_id;
  logic [31:0]    config_addr, config_data;
  logic           config_wr, config_rd;
  logic [31:0]    config_rd_data;
  logic           config_rd_valid;
  logic [4*T*W-1:0] in_wires, out_wires;

  always #5 clk = ~clk;

  pe_tile_param #(.WIDTH(W), .TRACKS(T)) dut (
    .clk             (clk),
    .reset           (reset),
    .tile_id         (tile_id),
    .config_addr     (config_addr),
    .config_data     (config_data),
    .config_wr       (config_wr),
    .config_rd       (config_rd),
    .config_rd_data  (config_rd_data),
    .config_rd_valid (config_rd_valid),
    .in_wires        (in_wires),
    .out_wires       (out_wires)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct { logic [1:0] op; logic [3:0] a; logic [3:0] b; logic [3:0] exp; } op_vec_t;
  typedef struct { int mod; int word; logic [31:0] data; logic [31:0] exp; } rb_vec_t;
  op_vec_t ops[8];
  rb_vec_t rbs[11];

  // Behavioural tile state: configuration as plain integers, one value per output.
  int          m_op, m_cb0, m_cb1, m_pe;
  int          m_sel[NO];
  int          m_flop[NO];
  bit          m_reg[NO];
  bit          m_en, m_rv;
  logic [31:0] m_rd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_op = 0; m_cb0 = 0; m_cb1 = 0; m_pe = 0; m_en = 1'b1; m_rv = 1'b0; m_rd = '0;
    for (int o = 0; o < NO; o++) begin
      m_sel[o] = 0; m_flop[o] = 0; m_reg[o] = 1'b0;
    end
  endtask

  function automatic int lane(input int s, input int t);
    return int'(in_wires[(s*T+t)*W +: W]);
  endfunction

  function automatic int mux_val(input int o);
    if (m_sel[o] == 0) return m_pe;
    return lane((o/T + m_sel[o]) % 4, o % T);
  endfunction

  function automatic int out_val(input int o);
    return m_reg[o] ? m_flop[o] : mux_val(o);
  endfunction

  function automatic int cb_val(input int sel);
    if (sel < T)   return lane(0, sel);
    if (sel < 2*T) return out_val(sel - T);
    return 0;
  endfunction

  function automatic int alu(input int op, input int a, input int b);
    case (op)
      0:       return a & b;
      1:       return a | b;
      2:       return a ^ b;
      default: return (a + b) % 16;
    endcase
  endfunction

  function automatic logic [63:0] model_out();
    logic [63:0] r;
    r = '0;
    for (int o = 0; o < NO; o++) r[o*W +: W] = 4'(out_val(o));
    return r;
  endfunction

  function automatic logic [31:0] model_read(input int mod, input int word);
    logic [31:0] r;
    r = '0;
    if (word != 0) return r;
    case (mod)
      4: r = 32'(m_op);
      5: r = 32'(m_cb1);
      6: r = 32'(m_cb0);
      7: for (int o = 0; o < NO; o++) r = r | (32'(m_sel[o]) << (2*o));
      8: for (int o = 0; o < NO; o++) r[o] = m_reg[o];
      9: r = 32'(m_en);
      default: ;
    endcase
    return r;
  endfunction

  task automatic model_write(input int mod, input int word, input logic [31:0] d);
    if (word != 0) return;
    case (mod)
      4: m_op  = int'(d & 32'h3);
      5: m_cb1 = int'(d & 32'h7);
      6: m_cb0 = int'(d & 32'h7);
      7: for (int o = 0; o < NO; o++) m_sel[o] = int'((d >> (2*o)) & 32'h3);
      8: for (int o = 0; o < NO; o++) m_reg[o] = d[o];
      9: m_en = d[0];
      default: ;
    endcase
  endtask

  // Advance one clock: model evaluates from pre-edge inputs, then state commits at the edge.
  task automatic tick();
    int          nmux[NO];
    int          npe;
    bit          acc;
    logic [31:0] nrd;
    for (int o = 0; o < NO; o++) nmux[o] = mux_val(o);
    npe = m_en ? alu(m_op, cb_val(m_cb0), cb_val(m_cb1)) : m_pe;
    acc = config_rd && (config_addr[15:0] == tile_id);
    nrd = acc ? model_read(int'(config_addr[23:16]), int'(config_addr[27:24])) : m_rd;
    if (config_wr && (config_addr[15:0] == tile_id))
      model_write(int'(config_addr[23:16]), int'(config_addr[27:24]), config_data);
    @(posedge clk);
    m_pe = npe;
    for (int o = 0; o < NO; o++) m_flop[o] = nmux[o];
    m_rv = acc;
    m_rd = nrd;
    #1;
  endtask

  function automatic logic [31:0] mk_addr(input int tile, input int mod, input int word);
    return {4'h0, 4'(word), 8'(mod), 16'(tile)};
  endfunction

  task automatic cfg_write(input int tile, input int mod, input int word, input logic [31:0] d);
    config_addr = mk_addr(tile, mod, word);
    config_data = d;
    config_wr   = 1'b1;
    tick();
    config_wr   = 1'b0;
  endtask

  task automatic cfg_read(input int tile, input int mod, input int word);
    config_addr = mk_addr(tile, mod, word);
    config_rd   = 1'b1;
    tick();
    config_rd   = 1'b0;
  endtask

  task automatic apply_reset();
    config_wr = 1'b0;
    config_rd = 1'b0;
    reset     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ops[0] = '{2'd0, 4'h9, 4'h8, 4'h8};
    ops[1] = '{2'd1, 4'h3, 4'h4, 4'h7};
    ops[2] = '{2'd2, 4'hF, 4'h5, 4'hA};
    ops[3] = '{2'd3, 4'h9, 4'h8, 4'h1};
    ops[4] = '{2'd3, 4'hF, 4'h1, 4'h0};
    ops[5] = '{2'd3, 4'h6, 4'h7, 4'hD};
    ops[6] = '{2'd0, 4'hC, 4'hA, 4'h8};
    ops[7] = '{2'd2, 4'h5, 4'h5, 4'h0};

    rbs[0]  = '{4,  0, 32'hFFFF_FFFF, 32'h0000_0003};
    rbs[1]  = '{5,  0, 32'hFFFF_FFFF, 32'h0000_0007};
    rbs[2]  = '{6,  0, 32'h0000_000D, 32'h0000_0005};
    rbs[3]  = '{7,  0, 32'h1234_5678, 32'h1234_5678};
    rbs[4]  = '{7,  1, 32'hFFFF_FFFF, 32'h0000_0000};
    rbs[5]  = '{8,  0, 32'hFFFF_FFFF, 32'h0000_FFFF};
    rbs[6]  = '{9,  0, 32'hFFFF_FFFE, 32'h0000_0000};
    rbs[7]  = '{9,  0, 32'h0000_0001, 32'h0000_0001};
    rbs[8]  = '{4,  1, 32'hFFFF_FFFF, 32'h0000_0000};
    rbs[9]  = '{10, 0, 32'hFFFF_FFFF, 32'h0000_0000};
    rbs[10] = '{3,  0, 32'hFFFF_FFFF, 32'h0000_0000};

    reset       = 1'b0;
    tile_id     = 16'd2;
    config_addr = '0;
    config_data = '0;
    config_wr   = 1'b0;
    config_rd   = 1'b0;
    in_wires    = '1;
    model_reset();

    // Reset state and first result after release.
    #12;
    check("rst_out", out_wires, 64'h0);
    check("rst_vld", config_rd_valid, 1'b0);
    check("rst_dat", config_rd_data, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    tick();
    check("rel_out", out_wires, 64'hFFFF_FFFF_FFFF_FFFF);

    // PE opcode table: CB0=N0, CB1=N1, every output shows pe_q.
    cfg_write(2, 5, 0, 32'h1);
    for (int i = 0; i < 8; i++) begin
      cfg_write(2, 4, 0, 32'(ops[i].op));
      in_wires = (64'(ops[i].b) << 4) | 64'(ops[i].a);
      tick();
      check("op_tbl", out_wires, {16{ops[i].exp}});
    end

    // Readback table, including out-of-range words and foreign module ids.
    apply_reset();
    for (int i = 0; i < 11; i++) begin
      cfg_write(2, rbs[i].mod, rbs[i].word, rbs[i].data);
      cfg_read(2, rbs[i].mod, rbs[i].word);
      check("rb_vld", config_rd_valid, 1'b1);
      check("rb_dat", config_rd_data, rbs[i].exp);
    end

    // Output (E,2) = index 6 taken from N2, first combinational then registered.
    apply_reset();
    in_wires = '0;
    cfg_write(2, 7, 0, 32'h0000_3000);
    in_wires[11:8] = 4'hA;
    #1;
    check("sb_comb_a", out_wires[27:24], 4'hA);
    in_wires[11:8] = 4'h5;
    #1;
    check("sb_comb_5", out_wires[27:24], 4'h5);
    cfg_write(2, 8, 0, 32'h0000_0040);
    in_wires[11:8] = 4'h3;
    #1;
    check("sb_reg_hold", out_wires[27:24], 4'h5);
    tick();
    check("sb_reg_dly", out_wires[27:24], 4'h3);

    // Write addressed to another tile is ignored.
    apply_reset();
    cfg_write(3, 5, 0, 32'h5);
    cfg_read(2, 5, 0);
    check("miss_vld", config_rd_valid, 1'b1);
    check("miss_dat", config_rd_data, 32'h0);

    // Same-cycle read and write of SB word 0.
    apply_reset();
    config_addr = mk_addr(2, 7, 0);
    config_data = 32'h0000_A5A5;
    config_wr   = 1'b1;
    config_rd   = 1'b1;
    tick();
    config_wr   = 1'b0;
    config_rd   = 1'b0;
    check("rw_vld", config_rd_valid, 1'b1);
    check("rw_old", config_rd_data, 32'h0);
    tick();
    check("rv_pulse", config_rd_valid, 1'b0);
    cfg_read(2, 7, 0);
    check("rw_new", config_rd_data, 32'h0000_A5A5);

    // pe_en hold, then asynchronous reset with a read in flight.
    apply_reset();
    cfg_write(2, 5, 0, 32'h1);
    cfg_write(2, 4, 0, 32'h2);
    in_wires = 64'h53;
    tick();
    check("xor_out", out_wires, {16{4'h6}});
    cfg_write(2, 9, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      in_wires = {$urandom, $urandom};
      tick();
      check("pe_hold", out_wires, {16{4'h6}});
    end
    cfg_read(2, 9, 0);
    check("pend_vld", config_rd_valid, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_out", out_wires, 64'h0);
    check("arst_vld", config_rd_valid, 1'b0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;

    // Randomized traffic with mixed config traffic against the model.
    for (int i = 0; i < 600; i++) begin
      in_wires    = {$urandom, $urandom};
      config_wr   = ($urandom_range(0, 3) == 0);
      config_rd   = ($urandom_range(0, 3) == 0);
      config_addr = mk_addr(($urandom_range(0, 4) == 0) ? 3 : 2,
                            $urandom_range(3, 10),
                            ($urandom_range(0, 3) == 0) ? 1 : 0);
      config_data = $urandom;
      #1;
      check("rnd_out", out_wires, model_out());
      tick();
      check("rnd_vld", config_rd_valid, m_rv);
      if (m_rv) check("rnd_dat", config_rd_data, m_rd);
    end
    config_wr = 1'b0;
    config_rd = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_tile_param.md
# pe_tile_param

Parametrised processing-element tile for the FPGA fabric, succeeding the fixed 1-bit, 4-track tile.
- Track count and datapath width are parameters.
- The PE computes one of four WIDTH-bit ops and always registers its result.
- Every switch-box output can be individually registered.
- Configuration is written through a qualified write strobe, and any configuration word can be read back with one cycle of latency.
- Tiles sit in the array grid and connect by abutment of side/track buses.

## Interface
Parameters:
- WIDTH, 1, bits per track and PE datapath width (1..16)
- TRACKS, 4, tracks per side (1..8); there are 4 sides: 0=N, 1=E, 2=S, 3=W
- CB_SEL_W, $clog2(2*TRACKS), connect-box select width (derived)

Ports:
- clk  in  1  fabric clock; all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- tile_id  in  16  this tile's address
- config_addr  in  32  [15:0] tile id, [23:16] module id, [27:24] word index
- config_data  in  32  write data
- config_wr  in  1  write strobe; a write occurs only on a cycle with config_wr=1 and an address match
- config_rd  in  1  read strobe; a read occurs only on a cycle with config_rd=1 and an address match
- config_rd_data  out  32  readback word, registered
- config_rd_valid  out  1  high for one cycle, the cycle after an accepted read
- in_wires  in  4*TRACKS*WIDTH  bus for side s, track t at [(s*TRACKS+t)*WIDTH +: WIDTH]
- out_wires  out  4*TRACKS*WIDTH  same packing as in_wires

## Operation
- Address match: config_addr[15:0]==tile_id and the module id is one of the following.
  - 4 (CLB), word 0: [1:0] opcode.
  - 5 (CB1), word 0: [CB_SEL_W-1:0] select.
  - 6 (CB0), word 0: [CB_SEL_W-1:0] select.
  - 7 (SB): 2-bit select per output o = s*TRACKS+t, packed 16 per word; word w holds outputs 16w..16w+15.
  - 8 (SB_REG): bit per output o, packed 32 per word.
  - 9 (CTRL), word 0: bit0 pe_en.
- Unmatched ids or out-of-range words: writes ignored; reads return 0 with config_rd_valid=1.
- Unused bits read back as 0.
- Connect boxes: select k < TRACKS picks in_wires side 0 track k. Select TRACKS+k picks out_wires side 0 track k. Selects ≥2*TRACKS pick 0.
- PE:
  - op_0 comes from CB0 and op_1 from CB1.
  - Opcodes: 0=AND, 1=OR, 2=XOR, 3=ADD mod 2^WIDTH (carry dropped).
  - pe_q <= result when pe_en=1, otherwise it holds.
- Switch box, output (s,t):
  - sel 0 = pe_q.
  - sel 1 = in side (s+1)%4 track t.
  - sel 2 = in side (s+2)%4 track t.
  - sel 3 = in side (s+3)%4 track t.
  - If SB_REG bit o=1, the output is driven from a flop of the mux result; otherwise the mux drives it combinationally.
- The CB1 feedback path from out_wires is loop-free because pe_q is always registered.

## Timing
- Reset values:
  - All config registers 0, so opcode=AND, CB sel=0, SB sel=0 (pe_q), all SB_REG=0.
  - pe_en resets to 1.
  - pe_q=0, SB flops=0, config_rd_data=0, config_rd_valid=0.
  - With reset asserted, out_wires=0 (every output selects pe_q).
- A config write is visible to the datapath on the cycle after the write edge.
- Reads: config_rd_data is valid on the cycle after the strobe.
- Simultaneous read and write to the same word: the read returns the old value.
- PE latency is 1 cycle from inputs to pe_q. A registered SB output adds 1 cycle; an unregistered one adds 0.
- Reset assertion mid-operation clears all state immediately, without waiting for clk; a pending read's valid is dropped.
- Reset release is synchronised externally.
- Changing SB_REG while traffic flows: the output switches source on the next cycle; the flop contents at that point are whatever was last sampled.

## Structure
- Shared package pe_tile_pkg: opcode constants, module-id constants (4..9), side-index constants, and the SB select encoding.
- Sub-module connect_box_param (WIDTH, TRACKS): select register plus 2*TRACKS:1 mux. Instantiated twice, as cb0 and cb1.
- The tile contains the address decode, CLB, SB mux/flop array and readback mux inline.

## Test plan
- Reset, then apply in_wires all ones, WIDTH=4, TRACKS=4 -> out_wires=0 during reset. One cycle after release, all outputs = 4'hF (AND of in side0 track0 with itself).
- Program CLB=ADD, CB0=0, CB1=1, in N0=4'h9, N1=4'h8 -> pe_q=4'h1 (carry dropped) one cycle later.
- Program SB sel output (E,2)=3 (from side N, track 2), then set its SB_REG bit -> output follows N2 combinationally, then with 1-cycle delay after the SB_REG write.
- Write CB1=0x5 to tile 3 while tile_id=2 -> no effect; readback of module 5 returns 0.
- Same-cycle write and read of SB word 0 with 0xA5A5 -> config_rd_data = old value, config_rd_valid=1. The next read returns 0xA5A5.
- Clear pe_en, toggle inputs for 3 cycles, then assert reset mid-stream -> pe_q holds while pe_en=0, then all outputs go to 0 immediately on reset.
